// File: rtl/case_9_mul_share_pkg.sv
// case_9_mul_share_pkg: default widths, requester count and id-width helper
// shared by the multiplier-sharing arbiter and its core.
package case_9_mul_share_pkg;
    localparam int NUM_REQ_DEF = 4;
    localparam int A_WIDTH_DEF = 13;
    localparam int B_WIDTH_DEF = 11;
    localparam int P_WIDTH_DEF = 13;

    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/case_9_mul_share_core.sv
// case_9_mul_share_core: full-precision signed multiply, purely combinational.
module case_9_mul_share_core
    import case_9_mul_share_pkg::*;
#(
    parameter int A_WIDTH = A_WIDTH_DEF,
    parameter int B_WIDTH = B_WIDTH_DEF
) (
    input  logic signed [A_WIDTH-1:0]         a_i,
    input  logic signed [B_WIDTH-1:0]         b_i,
    output logic signed [A_WIDTH+B_WIDTH-1:0] p_o
);
    assign p_o = a_i * b_i;
endmodule

// File: rtl/case_9_mul_share_arb.sv
// case_9_mul_share_arb: round-robin arbiter sharing one signed multiplier among NUM_REQ requesters.
// Define CASE_9_MUL_SHARE_SAT_EN for saturating reduction plus rsp_sat; otherwise the product wraps.
module case_9_mul_share_arb
    import case_9_mul_share_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int A_WIDTH = A_WIDTH_DEF,
    parameter int B_WIDTH = B_WIDTH_DEF,
    parameter int P_WIDTH = P_WIDTH_DEF,
    localparam int ID_W = id_width(NUM_REQ)
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic signed [P_WIDTH-1:0]  rsp_data
`ifdef CASE_9_MUL_SHARE_SAT_EN
    ,
    output logic                       rsp_sat
`endif
);
    localparam int F_WIDTH = A_WIDTH + B_WIDTH;

    logic [ID_W-1:0]           ptr_q, ptr_d, grant;
    logic                      found, xfer;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]           rsp_id_q, rsp_id_d;
    logic signed [P_WIDTH-1:0] rsp_data_q, rsp_data_d, prod_red;
    logic signed [A_WIDTH-1:0] a_sel;
    logic signed [B_WIDTH-1:0] b_sel;
    logic signed [F_WIDTH-1:0] prod;

    // Search starts at ptr and wraps, so the last winner drops to lowest priority.
    always_comb begin
        int idx;
        idx = 0;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = ID_W'(idx);
            end
        end
    end

    assign xfer      = found && (!rsp_valid_q || rsp_ready);
    assign req_ready = (xfer && ap_rst_n) ? NUM_REQ'(1) << grant : '0;
    assign a_sel     = req_a[int'(grant)*A_WIDTH +: A_WIDTH];
    assign b_sel     = req_b[int'(grant)*B_WIDTH +: B_WIDTH];

    case_9_mul_share_core #(
        .A_WIDTH(A_WIDTH),
        .B_WIDTH(B_WIDTH)
    ) u_core (
        .a_i(a_sel),
        .b_i(b_sel),
        .p_o(prod)
    );

`ifdef CASE_9_MUL_SHARE_SAT_EN
    localparam logic signed [F_WIDTH-1:0] P_MAX = {{(F_WIDTH-P_WIDTH+1){1'b0}}, {(P_WIDTH-1){1'b1}}};
    localparam logic signed [F_WIDTH-1:0] P_MIN = ~P_MAX;
    logic sat_q, sat_d, prod_hi, prod_lo;

    assign prod_hi  = prod > P_MAX;
    assign prod_lo  = prod < P_MIN;
    assign prod_red = prod_hi ? P_MAX[P_WIDTH-1:0] : prod_lo ? P_MIN[P_WIDTH-1:0] : prod[P_WIDTH-1:0];
    assign sat_d    = xfer ? (prod_hi || prod_lo) : sat_q;
    assign rsp_sat  = sat_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) sat_q <= 1'b0;
        else           sat_q <= sat_d;
    end
`else
    logic unused_hi;

    assign unused_hi = ^prod[F_WIDTH-1:P_WIDTH];
    assign prod_red  = prod[P_WIDTH-1:0];
`endif

    always_comb begin
        ptr_d       = xfer ? ((int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1) : ptr_q;
        rsp_valid_d = xfer || (rsp_valid_q && !rsp_ready);
        rsp_id_d    = xfer ? grant : rsp_id_q;
        rsp_data_d  = xfer ? prod_red : rsp_data_q;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_case_9_mul_share_arb.sv
// tb_case_9_mul_share_arb: directed and randomized checks of the shared-multiplier arbiter
// against a transaction-level reference model (follows CASE_9_MUL_SHARE_SAT_EN like the DUT).
module tb_case_9_mul_share_arb;
    localparam int N  = 4;
    localparam int AW = 13;
    localparam int BW = 11;
    localparam int PW = 13;

    logic                      ap_clk = 1'b0;
    logic                      ap_rst_n;
    logic [N-1:0]              req_valid;
    logic [N-1:0]              req_ready;
    logic [N*AW-1:0]           req_a;
    logic [N*BW-1:0]           req_b;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [1:0]                rsp_id;
    logic signed [PW-1:0]      rsp_data;
`ifdef CASE_9_MUL_SHARE_SAT_EN
    logic                      rsp_sat;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int a_v[N];
    int b_v[N];
    int m_ptr, m_id, m_data, m_sat;
    bit m_val;

    case_9_mul_share_arb #(
        .NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),
        .rsp_data(rsp_data)
`ifdef CASE_9_MUL_SHARE_SAT_EN
        ,
        .rsp_sat(rsp_sat)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reduction of the exact product to the result width.
    function automatic int reduce(input int full);
        int w;
`ifdef CASE_9_MUL_SHARE_SAT_EN
        if (full > (1 << (PW-1)) - 1) return (1 << (PW-1)) - 1;
        if (full < -(1 << (PW-1))) return -(1 << (PW-1));
        w = full;
`else
        w = full & ((1 << PW) - 1);
        if (w >= (1 << (PW-1))) w -= (1 << PW);
`endif
        return w;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_a[i*AW +: AW] = AW'(a_v[i]);
            req_b[i*BW +: BW] = BW'(b_v[i]);
        end
    endtask

    // One clock: compare the DUT with the model, then advance the model across the edge.
    task automatic cycle();
        int g, full;
        #1;
        g = -1;
        if (!m_val || rsp_ready)
            for (int k = 0; k < N; k++)
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        check("req_ready", int'(req_ready), (g < 0) ? 0 : (1 << g));
        check("rsp_valid", int'(rsp_valid), int'(m_val));
        if (m_val) begin
            check("rsp_id", int'(rsp_id), m_id);
            check("rsp_data", int'(rsp_data), m_data);
`ifdef CASE_9_MUL_SHARE_SAT_EN
            check("rsp_sat", int'(rsp_sat), m_sat);
`endif
        end
        @(posedge ap_clk);
        if (g >= 0) begin
            full   = a_v[g] * b_v[g];
            m_val  = 1'b1;
            m_id   = g;
            m_data = reduce(full);
            m_sat  = (m_data != full) ? 1 : 0;
            m_ptr  = (g + 1) % N;
        end else if (rsp_ready) begin
            m_val = 1'b0;
        end
        @(negedge ap_clk);
    endtask

    task automatic do_reset();
        req_valid = 4'($urandom_range(1, 15));
        #2 ap_rst_n = 1'b0;
        #1;
        check("rst_valid", int'(rsp_valid), 0);
        check("rst_ready", int'(req_ready), 0);
        check("rst_id", int'(rsp_id), 0);
        check("rst_data", int'(rsp_data), 0);
`ifdef CASE_9_MUL_SHARE_SAT_EN
        check("rst_sat", int'(rsp_sat), 0);
`endif
        m_val = 1'b0;
        m_ptr = 0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    task automatic first_grant();
        int v;
        v = int'($urandom_range(1, 15));
        req_valid = 4'(v);
        #1 check("rst_first_grant", int'(req_ready), v & -v);
        cycle();
    endtask

    function automatic int rand_a();
        if ($urandom_range(0, 7) == 0) return $urandom_range(0, 1) ? 4095 : -4096;
        return int'($urandom_range(0, 8191)) - 4096;
    endfunction

    function automatic int rand_b();
        if ($urandom_range(0, 7) == 0) return $urandom_range(0, 1) ? 1023 : -1024;
        return int'($urandom_range(0, 2047)) - 1024;
    endfunction

    initial begin
        ap_rst_n  = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin a_v[i] = 0; b_v[i] = 0; end
        drive();
        @(negedge ap_clk);
        do_reset();

        // Single requester: 3 * -5.
        a_v[0] = 3; b_v[0] = -5; req_valid = 4'b0001; drive();
        cycle();
        req_valid = '0;
        #1 check("s1_data", int'(rsp_data), -15);
        check("s1_id", int'(rsp_id), 0);
        cycle();

        // All requesters busy from ptr=0: strict rotation, one result per cycle.
        do_reset();
        for (int i = 0; i < N; i++) begin a_v[i] = rand_a(); b_v[i] = rand_b(); end
        req_valid = 4'b1111; drive();
        for (int i = 0; i < 5; i++) begin
            #1 check("rr_grant", int'(req_ready), 1 << (i % N));
            cycle();
        end
        req_valid = '0;
        cycle();

        // Extreme operands.
        a_v[0] = 4095; b_v[0] = 1023; req_valid = 4'b0001; drive();
        cycle();
        req_valid = '0;
`ifdef CASE_9_MUL_SHARE_SAT_EN
        #1 check("max_data", int'(rsp_data), 4095);
        check("max_sat", int'(rsp_sat), 1);
`else
        #1 check("max_data", int'(rsp_data), 3073);
`endif
        a_v[0] = -4096; b_v[0] = -1024; req_valid = 4'b0001; drive();
        cycle();
        req_valid = '0;
`ifdef CASE_9_MUL_SHARE_SAT_EN
        #1 check("min_data", int'(rsp_data), 4095);
        check("min_sat", int'(rsp_sat), 1);
`else
        #1 check("min_data", int'(rsp_data), 0);
`endif
        cycle();

        // Backpressure: hold for 3 cycles, then drain and load in one cycle.
        a_v[1] = rand_a(); b_v[1] = rand_b(); req_valid = 4'b0010; drive();
        cycle();
        rsp_ready = 1'b0; req_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1 check("stall_ready", int'(req_ready), 0);
            check("stall_id", int'(rsp_id), 1);
            cycle();
        end
        a_v[2] = rand_a(); b_v[2] = rand_b(); rsp_ready = 1'b1; req_valid = 4'b0100; drive();
        #1 check("drain_ready", int'(req_ready), 4);
        cycle();
        req_valid = '0;
        #1 check("drain_valid", int'(rsp_valid), 1);
        check("drain_id", int'(rsp_id), 2);
        cycle();

        // Random traffic with a reset pulse in the middle.
        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < N; i++) begin a_v[i] = rand_a(); b_v[i] = rand_b(); end
            req_valid = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            drive();
            if (t == 150) begin
                req_valid = 4'b1111; rsp_ready = 1'b0;
                cycle();
                do_reset();
                rsp_ready = 1'b1;
                first_grant();
            end else begin
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
